axi_rd_mem_slave: RTL and testbench

- AXI4 read-only responder that answers cache line refill bursts, as issued by the icache/dcache miss FSMs, from an internal word-addressed memory.
- Used as the instruction/data backing store in block-level and core-level simulation.
- Accepts one AR request at a time, waits a programmable latency, then streams the beats with correct rlast and backpressure handling.
- A side init port preloads memory contents.

---
 rtl/axi_rd_mem_slave.sv | 196 +++++++++++++++++++
 tb/tb_axi_rd_mem_slave.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_rd_mem_slave.sv
// AXI4 read-only memory responder for cache-line refill bursts.
// Serves one AR at a time after a fixed latency; side port preloads memory.
module axi_rd_mem_slave #(
  parameter logic [31:0] ADDR_BASE  = 32'h1c00_0000,
  parameter int unsigned DEPTH_LOG2 = 14,
  parameter int unsigned LATENCY    = 2
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  arvalid,
  output logic                  arready,
  input  logic [31:0]           araddr,
  input  logic [7:0]            arlen,
  input  logic [2:0]            arsize,
  input  logic [1:0]            arburst,
  input  logic [3:0]            arid,
  output logic                  rvalid,
  input  logic                  rready,
  output logic [31:0]           rdata,
  output logic [1:0]            rresp,
  output logic                  rlast,
  output logic [3:0]            rid,
  input  logic                  init_we,
  input  logic [DEPTH_LOG2-1:0] init_addr,
  input  logic [31:0]           init_wdata
);

  typedef enum logic [1:0] {IDLE, WAIT, BURST} state_e;

  localparam logic [29:0] BASE_W   = ADDR_BASE[31:2];
  localparam logic [3:0]  LAT_INIT = 4'(LATENCY - 1);

  logic [31:0] mem [2**DEPTH_LOG2];

  state_e      state_q, state_d;
  logic [29:0] addr_q, addr_d;
  logic [7:0]  len_q, len_d;
  logic [1:0]  burst_q, burst_d;
  logic [3:0]  id_q, id_d;
  logic        err_q, err_d;
  logic [3:0]  lat_q, lat_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        rvalid_q, rvalid_d;
  logic        rlast_q, rlast_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  rresp_q, rresp_d;
  logic [3:0]  rid_q, rid_d;

  logic [29:0] addr_nxt, rd_addr, diff_w;
  logic [31:0] beat_data;
  logic [1:0]  beat_resp;
  logic        in_range;
  logic        unused_ok;

  assign unused_ok = ^araddr[1:0];

  // Word-granular address step; INCR wraps within the memory-sized region.
  function automatic logic [29:0] next_addr(input logic [29:0] w, input logic [1:0] burst,
                                            input logic [7:0] len);
    logic [29:0] m;
    logic [29:0] inc;
    m   = {22'b0, len};
    inc = w + 30'd1;
    case (burst)
      2'b01:   next_addr = {w[29:DEPTH_LOG2], inc[DEPTH_LOG2-1:0]};
      2'b10:   next_addr = (w & ~m) | (inc & m);
      default: next_addr = w;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (init_we) mem[init_addr] <= init_wdata;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      len_q    <= '0;
      burst_q  <= '0;
      id_q     <= '0;
      err_q    <= 1'b0;
      lat_q    <= '0;
      cnt_q    <= '0;
      rvalid_q <= 1'b0;
      rlast_q  <= 1'b0;
      rdata_q  <= '0;
      rresp_q  <= '0;
      rid_q    <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      len_q    <= len_d;
      burst_q  <= burst_d;
      id_q     <= id_d;
      err_q    <= err_d;
      lat_q    <= lat_d;
      cnt_q    <= cnt_d;
      rvalid_q <= rvalid_d;
      rlast_q  <= rlast_d;
      rdata_q  <= rdata_d;
      rresp_q  <= rresp_d;
      rid_q    <= rid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (arvalid) state_d = WAIT;
      WAIT:    if (lat_q == '0) state_d = BURST;
      BURST:   if (rready && rlast_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Beat 0 reads the latched start address; later beats read the stepped one.
  always_comb begin
    addr_nxt  = next_addr(addr_q, burst_q, len_q);
    rd_addr   = (state_q == WAIT) ? addr_q : addr_nxt;
    diff_w    = rd_addr - BASE_W;
    in_range  = (diff_w >> DEPTH_LOG2) == '0;
    beat_data = '0;
    beat_resp = 2'b10;
    if (!err_q && in_range) begin
      beat_data = mem[diff_w[DEPTH_LOG2-1:0]];
      beat_resp = 2'b00;
    end
  end

  always_comb begin
    addr_d   = addr_q;
    len_d    = len_q;
    burst_d  = burst_q;
    id_d     = id_q;
    err_d    = err_q;
    lat_d    = lat_q;
    cnt_d    = cnt_q;
    rvalid_d = rvalid_q;
    rlast_d  = rlast_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    rid_d    = rid_q;
    case (state_q)
      IDLE: begin
        if (arvalid) begin
          addr_d  = araddr[31:2];
          len_d   = arlen;
          burst_d = arburst;
          id_d    = arid;
          err_d   = (arsize != 3'b010) || (arburst == 2'b11) ||
                    ((arburst == 2'b10) && !(arlen == 8'd1 || arlen == 8'd3 ||
                                             arlen == 8'd7 || arlen == 8'd15));
          lat_d   = LAT_INIT;
          cnt_d   = '0;
        end
      end
      WAIT: begin
        if (lat_q == '0) begin
          rvalid_d = 1'b1;
          rlast_d  = (len_q == '0);
          rdata_d  = beat_data;
          rresp_d  = beat_resp;
          rid_d    = id_q;
        end else begin
          lat_d = lat_q - 4'd1;
        end
      end
      BURST: begin
        if (rready) begin
          if (rlast_q) begin
            rvalid_d = 1'b0;
            rlast_d  = 1'b0;
          end else begin
            addr_d  = addr_nxt;
            cnt_d   = cnt_q + 8'd1;
            rdata_d = beat_data;
            rresp_d = beat_resp;
            rlast_d = (cnt_q + 8'd1 == len_q);
          end
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    arready = (state_q == IDLE);
    rvalid  = rvalid_q;
    rlast   = rlast_q;
    rdata   = rdata_q;
    rresp   = rresp_q;
    rid     = rid_q;
  end

endmodule

// File: tb/tb_axi_rd_mem_slave.sv
// Directed bench for axi_rd_mem_slave: a burst-level model predicts every beat
// and the rvalid/arready timing; literal checks pin the model on key bursts.
module tb_axi_rd_mem_slave;

  localparam logic [31:0] BASE   = 32'h1c00_0000;
  localparam int          DL     = 14;
  localparam int          LAT    = 2;
  localparam logic [31:0] DEPTH  = 32'(1 << DL);
  localparam logic [31:0] REGION = DEPTH * 4;

  logic          clk, rstn;
  logic          arvalid, arready;
  logic [31:0]   araddr;
  logic [7:0]    arlen;
  logic [2:0]    arsize;
  logic [1:0]    arburst;
  logic [3:0]    arid;
  logic          rvalid, rready;
  logic [31:0]   rdata;
  logic [1:0]    rresp;
  logic          rlast;
  logic [3:0]    rid;
  logic          init_we;
  logic [DL-1:0] init_addr;
  logic [31:0]   init_wdata;

  axi_rd_mem_slave #(.ADDR_BASE(BASE), .DEPTH_LOG2(DL), .LATENCY(LAT)) dut (
    .clk(clk), .rstn(rstn),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arlen(arlen),
    .arsize(arsize), .arburst(arburst), .arid(arid),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
    .rlast(rlast), .rid(rid),
    .init_we(init_we), .init_addr(init_addr), .init_wdata(init_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
    logic [3:0]  id;
  } beat_t;

  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  int          due = 0;
  beat_t       q[$];
  logic [31:0] mdl_mem [int];
  logic [31:0] acc_data[$];
  logic [15:0] acc_last, acc_err;
  int          hs_cyc[$];
  int          last_cyc[$];
  int          rv_rise_cyc = 0;
  logic        rv_prev = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Expected beats from the AXI burst rules in byte-address arithmetic.
  task automatic model_ar(input logic [31:0] addr, input logic [7:0] len,
                          input logic [1:0] burst, input logic [2:0] size,
                          input logic [3:0] id);
    logic [31:0] a, off, bnd;
    bit          err;
    beat_t       b;
    int          n;
    n   = int'(len) + 1;
    err = (size != 3'b010) || (burst == 2'b11) ||
          (burst == 2'b10 && !(n == 2 || n == 4 || n == 8 || n == 16));
    a   = addr & ~32'd3;
    bnd = 32'(n * 4);
    for (int i = 0; i < n; i++) begin
      off = (a - BASE) >> 2;
      if (err || off >= DEPTH) begin
        b.data = '0;
        b.resp = 2'b10;
      end else begin
        b.data = mdl_mem.exists(int'(off)) ? mdl_mem[int'(off)] : 32'hDEAD_BEEF;
        b.resp = 2'b00;
      end
      b.last = (i == n - 1);
      b.id   = id;
      q.push_back(b);
      case (burst)
        2'b01:   a = (a / REGION) * REGION + ((a % REGION) + 32'd4) % REGION;
        2'b10:   a = (a / bnd) * bnd + ((a % bnd) + 32'd4) % bnd;
        default: ;
      endcase
    end
  endtask

  always @(posedge clk) cyc++;

  // Inputs settle #1 after posedge, so values seen here are those the next edge samples.
  always @(negedge clk) begin
    bit exp_v;
    if (!rstn) begin
      chk("rst_rvalid", 32'(rvalid), 32'd0);
      chk("rst_arready", 32'(arready), 32'd1);
      chk("rst_rlast", 32'(rlast), 32'd0);
      chk("rst_rdata", rdata, 32'd0);
      chk("rst_rid", 32'(rid), 32'd0);
      q.delete();
      rv_prev = 1'b0;
    end else begin
      exp_v = (q.size() > 0) && (cyc >= due);
      chk("rvalid", 32'(rvalid), 32'(exp_v));
      chk("arready", 32'(arready), 32'(q.size() == 0));
      if (rvalid && !rv_prev) rv_rise_cyc = cyc;
      rv_prev = rvalid;
      if (exp_v && rvalid) begin
        chk("rdata", rdata, q[0].data);
        chk("rresp", 32'(rresp), 32'(q[0].resp));
        chk("rlast", 32'(rlast), 32'(q[0].last));
        chk("rid", 32'(rid), 32'(q[0].id));
        if (rready) begin
          acc_data.push_back(rdata);
          acc_last = {acc_last[14:0], rlast};
          acc_err  = {acc_err[14:0], rresp == 2'b10};
          if (rlast) last_cyc.push_back(cyc + 1);
          void'(q.pop_front());
        end
      end
      if (arvalid && arready) begin
        hs_cyc.push_back(cyc + 1);
        due = cyc + 1 + LAT;
        model_ar(araddr, arlen, arburst, arsize, arid);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input int idx, input logic [31:0] d);
    init_we    = 1'b1;
    init_addr  = DL'(idx);
    init_wdata = d;
    tick();
    init_we    = 1'b0;
    mdl_mem[idx] = d;
  endtask

  task automatic issue(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                       input logic [2:0] size, input logic [3:0] id, input bit keep);
    int k;
    araddr  = addr;
    arlen   = len;
    arburst = burst;
    arsize  = size;
    arid    = id;
    arvalid = 1'b1;
    for (k = 0; k < 200; k++) begin
      @(negedge clk);
      if (arready) break;
    end
    if (k == 200) chk("ar_timeout", 32'd1, 32'd0);
    tick();
    if (!keep) arvalid = 1'b0;
  endtask

  task automatic wait_idle();
    int k;
    for (k = 0; k < 200; k++) begin
      @(negedge clk);
      if (q.size() == 0 && !rvalid) break;
    end
    if (k == 200) chk("burst_timeout", 32'd1, 32'd0);
    tick();
  endtask

  task automatic clr();
    acc_data.delete();
    acc_last = '0;
    acc_err  = '0;
  endtask

  task automatic chk_data(input string nm, input int n, input logic [31:0] e0,
                          input logic [31:0] e1, input logic [31:0] e2, input logic [31:0] e3);
    logic [31:0] e[4];
    e = '{e0, e1, e2, e3};
    chk({nm, "_beats"}, 32'(acc_data.size()), 32'(n));
    for (int i = 0; i < n && i < acc_data.size(); i++)
      chk($sformatf("%s_data%0d", nm, i), acc_data[i], e[i]);
  endtask

  initial begin
    rstn = 1'b0; arvalid = 1'b0; araddr = '0; arlen = '0; arsize = 3'b010;
    arburst = 2'b01; arid = '0; rready = 1'b0; init_we = 1'b0; init_addr = '0;
    init_wdata = '0;
    acc_last = '0; acc_err = '0;
    repeat (3) tick();
    rstn = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) preload(i, 32'hA0 + 32'(i));

    // Basic INCR burst
    clr(); rready = 1'b1;
    issue(BASE, 8'd3, 2'b01, 3'b010, 4'd5, 1'b0);
    wait_idle();
    chk_data("t1", 4, 32'hA0, 32'hA1, 32'hA2, 32'hA3);
    chk("t1_last", 32'(acc_last), 32'h1);
    chk("t1_latency", 32'(rv_rise_cyc - hs_cyc[$]), 32'd2);

    // rready backpressure 1,0,0,1,0,1,1
    clr(); rready = 1'b0;
    issue(BASE, 8'd3, 2'b01, 3'b010, 4'd5, 1'b0);
    begin
      bit pat[7];
      pat = '{1, 0, 0, 1, 0, 1, 1};
      for (int i = 0; i < 7; i++) begin rready = pat[i]; tick(); end
    end
    rready = 1'b1;
    wait_idle();
    chk_data("t2", 4, 32'hA0, 32'hA1, 32'hA2, 32'hA3);

    // WRAP from word 2
    clr();
    issue(BASE + 32'd8, 8'd3, 2'b10, 3'b010, 4'd3, 1'b0);
    wait_idle();
    chk_data("t3", 4, 32'hA2, 32'hA3, 32'hA0, 32'hA1);
    chk("t3_last", 32'(acc_last), 32'h1);

    // Below-base address, then illegal size
    clr();
    issue(32'h1bff_fffc, 8'd1, 2'b01, 3'b010, 4'd1, 1'b0);
    wait_idle();
    chk_data("t4a", 2, 32'h0, 32'h0, 32'h0, 32'h0);
    chk("t4a_err", 32'(acc_err), 32'h3);
    chk("t4a_last", 32'(acc_last), 32'h1);
    clr();
    issue(BASE, 8'd2, 2'b01, 3'b001, 4'd2, 1'b0);
    wait_idle();
    chk("t4b_err", 32'(acc_err), 32'h7);

    // Reset after the second beat of a 4-beat burst
    clr();
    issue(BASE, 8'd3, 2'b01, 3'b010, 4'd7, 1'b0);
    for (int k = 0; k < 50; k++) begin
      tick();
      if (acc_data.size() >= 2) break;
    end
    chk("t5_beats_before_rst", 32'(acc_data.size()), 32'd2);
    rstn = 1'b0;
    tick(); tick();
    rstn = 1'b1;
    tick(); tick();
    clr();
    issue(BASE + 32'd4, 8'd1, 2'b01, 3'b010, 4'd8, 1'b0);
    wait_idle();
    chk_data("t5", 2, 32'hA1, 32'hA2, 32'h0, 32'h0);

    // Back-to-back requests with arvalid held high
    clr();
    issue(BASE, 8'd1, 2'b01, 3'b010, 4'd1, 1'b1);
    issue(BASE + 32'd8, 8'd1, 2'b01, 3'b010, 4'd2, 1'b0);
    wait_idle();
    chk_data("t6", 4, 32'hA0, 32'hA1, 32'hA2, 32'hA3);
    chk("t6_gap", 32'(hs_cyc[$] - last_cyc[$-1]), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    fails++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog");
  end

endmodule
